// File: rtl/sqrt_pkg.sv
// Shared widths, flag bit positions and scheduler state encoding for the sqrt scheduler.
// Optional watchdog is enabled with the SQRT_SCHED_WDOG_EN macro (see sqrt_sched.sv).
package sqrt_pkg;

  localparam int MANT_W = 11;
  localparam int EXP_W  = 7;
  localparam int FLAG_W = 5;

  // Flag vector layout {sign,is_nan,is_pinf,is_ninf,is_num}
  localparam int FLAG_SIGN = 4;
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_PINF = 2;
  localparam int FLAG_NINF = 1;
  localparam int FLAG_NUM  = 0;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP
  } sched_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_sched_if.sv
// Requester/consumer side of the sqrt scheduler: per-slot operand ports plus the tagged response.
// master = requesters and consumer, slave = scheduler.
interface sqrt_sched_if #(
  parameter int NREQ = 4
) ();
  import sqrt_pkg::*;

  localparam int ID_W = id_width(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*FLAG_W-1:0] req_flags;
  logic [NREQ*MANT_W-1:0] req_mant;
  logic [NREQ*EXP_W-1:0]  req_exp;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_sign;
  logic [EXP_W-1:0]  rsp_exp;
  logic [MANT_W-1:0] rsp_mant;
  logic              rsp_err;

  modport master (
    output req_valid, req_flags, req_mant, req_exp, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_mant, rsp_err
  );

  modport slave (
    input  req_valid, req_flags, req_mant, req_exp, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_mant, rsp_err
  );

endinterface

// File: rtl/sqrt_rr_arb.sv
// Combinational rotate-priority encoder: first set request at or above ptr, wrapping modulo NREQ.
// Outputs a one-hot grant, its index and an any-request flag.
module sqrt_rr_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [ID_W-1:0] pos_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pos
    assign pos_arr[gi] = ID_W'((int'(ptr) + gi) % NREQ);
  end

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[pos_arr[k]]) begin
        any = 1'b1;
        idx = pos_arr[k];
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// Round-robin scheduler sharing one digit-by-digit sqrt core among NREQ requesters.
// Define SQRT_SCHED_WDOG_EN to abort stuck jobs after WDOG_CYCLES BUSY cycles (rsp_err=1).
module sqrt_sched
  import sqrt_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WDOG_CYCLES = 16
) (
  input  logic               clk,
  input  logic               enable,
  sqrt_sched_if.slave        bus,
  output logic               core_en,
  output logic               core_n_valid,
  output logic [FLAG_W-1:0]  core_flags,
  output logic [MANT_W-1:0]  core_mant,
  output logic [EXP_W-1:0]   core_exp,
  input  logic               core_it_valid,
  input  logic               core_result,
  input  logic               core_sign,
  input  logic [EXP_W-1:0]   core_exp_o,
  input  logic [MANT_W-1:0]  core_mant_o
);

  localparam int ID_W = id_width(NREQ);

  if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 2 || WDOG_CYCLES > 31) begin : g_param_check
    $error("sqrt_sched: NREQ must be 2..8 and WDOG_CYCLES 2..31");
  end

  sched_state_t      state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic              core_en_reg;
  logic              core_n_valid_reg;
  logic [FLAG_W-1:0] core_flags_reg;
  logic [MANT_W-1:0] core_mant_reg;
  logic [EXP_W-1:0]  core_exp_reg;
  logic              rsp_valid_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              rsp_sign_reg;
  logic [EXP_W-1:0]  rsp_exp_reg;
  logic [MANT_W-1:0] rsp_mant_reg;
  logic              rsp_err_reg;
`ifdef SQRT_SCHED_WDOG_EN
  logic [4:0]        wdog_cnt_reg;
`endif

  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic [ID_W-1:0]   ptr_next;
  logic [FLAG_W-1:0] sel_flags;
  logic [MANT_W-1:0] sel_mant;
  logic [EXP_W-1:0]  sel_exp;
  logic              done;

  sqrt_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Grants are only offered from IDLE, so the response accept cycle never grants.
  assign bus.req_ready = (enable && state_reg == IDLE) ? arb_gnt : '0;

  assign sel_flags = bus.req_flags[int'(arb_idx)*FLAG_W +: FLAG_W];
  assign sel_mant  = bus.req_mant[int'(arb_idx)*MANT_W +: MANT_W];
  assign sel_exp   = bus.req_exp[int'(arb_idx)*EXP_W +: EXP_W];
  assign ptr_next  = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
  assign done      = core_it_valid & core_result;

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= '0;
      core_en_reg      <= 1'b0;
      core_n_valid_reg <= 1'b0;
      core_flags_reg   <= '0;
      core_mant_reg    <= '0;
      core_exp_reg     <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_id_reg       <= '0;
      rsp_sign_reg     <= 1'b0;
      rsp_exp_reg      <= '0;
      rsp_mant_reg     <= '0;
      rsp_err_reg      <= 1'b0;
`ifdef SQRT_SCHED_WDOG_EN
      wdog_cnt_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            core_flags_reg   <= sel_flags;
            core_mant_reg    <= sel_mant;
            core_exp_reg     <= sel_exp;
            rsp_id_reg       <= arb_idx;
            rr_ptr_reg       <= ptr_next;
            core_en_reg      <= 1'b1;
            core_n_valid_reg <= 1'b1;
            state_reg        <= LAUNCH;
          end
        end
        LAUNCH: begin
          core_n_valid_reg <= 1'b0;
`ifdef SQRT_SCHED_WDOG_EN
          wdog_cnt_reg     <= '0;
`endif
          state_reg        <= BUSY;
        end
        BUSY: begin
          if (done) begin
            rsp_sign_reg  <= core_sign;
            rsp_exp_reg   <= core_exp_o;
            rsp_mant_reg  <= core_mant_o;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            core_en_reg   <= 1'b0;
            state_reg     <= RESP;
`ifdef SQRT_SCHED_WDOG_EN
          end else if (wdog_cnt_reg == 5'(WDOG_CYCLES - 1)) begin
            // This is the last allowed BUSY cycle; abort with an error response.
            rsp_sign_reg  <= 1'b0;
            rsp_exp_reg   <= '0;
            rsp_mant_reg  <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            core_en_reg   <= 1'b0;
            state_reg     <= RESP;
          end else begin
            wdog_cnt_reg  <= wdog_cnt_reg + 5'd1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign core_en       = core_en_reg;
  assign core_n_valid  = core_n_valid_reg;
  assign core_flags    = core_flags_reg;
  assign core_mant     = core_mant_reg;
  assign core_exp      = core_exp_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_sign  = rsp_sign_reg;
  assign bus.rsp_exp   = rsp_exp_reg;
  assign bus.rsp_mant  = rsp_mant_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule
